piso_tx_74: RTL and testbench

// - Parallel-in/serial-out transmitter: the sending counterpart to the flip-flop/latch receive chips in the emulator.
// - Captures a WIDTH-bit word on a load request, then shifts it out MSB-first, one bit per enabled clock.
// - Modelled as a 74-series composite: 165-style shift register, 161-style bit counter, 74-style status flops.
// - Drives serial links between emulated boards and feeds downstream shift-in chips.

---
 rtl/piso_tx_74_counter_161.sv | 28 ++
 rtl/piso_tx_74.sv | 90 +++++++++
 tb/tb_piso_tx_74.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/piso_tx_74_counter_161.sv
// rtl/piso_tx_74_counter_161.sv - loadable down-counter with async clear and terminal-zero flag
// Counts down on en and parks at zero; it never wraps.
module counter_161 #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         en,
  output logic         tz
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= din;
    end else if (en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign tz = (r_cnt == '0);

endmodule

// File: rtl/piso_tx_74.sv
// rtl/piso_tx_74.sv - parallel-in/serial-out transmitter, MSB first
// 165-style shift register and IDLE/SHIFT/DONE sequencer; bit counting lives in counter_161.
module piso_tx_74 #(
  parameter int WIDTH = 8
) (
  input  logic             cp,
  input  logic             mrn,
  input  logic [WIDTH-1:0] d,
  input  logic             pln,
  input  logic             ce,
  input  logic             ds,
  output logic             q7,
  output logic             q7n,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LOAD_VAL = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic             r_busy;
  logic             r_done;
  logic             w_load;
  logic             w_shift;
  logic             w_tz;

  // Loads are only honoured outside SHIFT, so a word in flight is never disturbed.
  assign w_load  = (r_state != S_SHIFT) && !pln;
  assign w_shift = (r_state == S_SHIFT) && ce;

  counter_161 #(.W(CW)) u_cnt (
    .clk   (cp),
    .clr_n (mrn),
    .load  (w_load),
    .din   (LOAD_VAL),
    .en    (w_shift),
    .tz    (w_tz)
  );

  always_ff @(posedge cp or negedge mrn) begin
    if (!mrn) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (!pln) begin
            r_sr    <= d;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          if (ce) begin
            r_sr <= {r_sr[WIDTH-2:0], ds};
            // The terminal-zero edge still shifts: the last bit leaves here.
            if (w_tz) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign q7   = r_sr[WIDTH-1];
  assign q7n  = ~r_sr[WIDTH-1];
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_piso_tx_74.sv
// tb/tb_piso_tx_74.sv - scoreboard bench for piso_tx_74
module tb_piso_tx_74;

  logic       clk = 1'b0;
  logic       mrn = 1'b0;
  logic [7:0] d   = 8'h00;
  logic       pln = 1'b1;
  logic       ce  = 1'b0;
  logic       ds  = 1'b0;
  logic       q7, q7n, busy, done;

  int n_tests  = 0;
  int n_fail   = 0;
  int busy_run = 0;
  int last_run = 0;
  int n_done   = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  piso_tx_74 #(.WIDTH(8)) dut (
    .cp   (clk),
    .mrn  (mrn),
    .d    (d),
    .pln  (pln),
    .ce   (ce),
    .ds   (ds),
    .q7   (q7),
    .q7n  (q7n),
    .busy (busy),
    .done (done)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] w);
    d   = w;
    pln = 1'b0;
    push_word(w);
    tick();
    pln = 1'b1;
  endtask

  task automatic wait_done(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done) seen = 1'b1;
    end
  endtask

  // Monitor: each busy cycle shows the head bit; a ce-qualified cycle retires it.
  always @(negedge clk) begin
    if (mrn) begin
      if (busy) begin
        busy_run++;
        check("sb_avail", 16'(exp_q.size() != 0), 16'd1);
        if (exp_q.size() != 0) begin
          check("q7_bit", q7, exp_q[0]);
          check("q7n_inv", q7n, !exp_q[0]);
          if (ce) void'(exp_q.pop_front());
        end
      end
      if (done) begin
        last_run = busy_run;
        busy_run = 0;
        n_done++;
      end
    end else begin
      busy_run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    bit seen;
    int nd;

    #12;
    check("rst_q7", q7, 0);
    check("rst_q7n", q7n, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk);
    #1;
    mrn = 1'b1;
    tick();

    // plain word
    ce = 1'b1;
    load_word(8'hA5);
    check("a5_busy", busy, 1);
    check("a5_msb", q7, 1);
    wait_done(20, seen);
    check("a5_done", seen, 1);
    check("a5_run", last_run, 8);
    @(negedge clk);
    #1;
    check("a5_idle_busy", busy, 0);
    check("a5_idle_done", done, 0);

    // stall after the second bit
    tick();
    load_word(8'hF0);
    tick();
    tick();
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_q7", q7, 1);
      check("stall_busy", busy, 1);
      tick();
    end
    ce = 1'b1;
    wait_done(30, seen);
    check("stall_done", seen, 1);
    check("stall_run", last_run, 11);

    // load request during SHIFT must be ignored
    tick();
    tick();
    load_word(8'hFF);
    tick();
    d   = 8'h00;
    pln = 1'b0;
    tick();
    tick();
    tick();
    pln = 1'b1;
    wait_done(20, seen);
    check("ign_done", seen, 1);
    check("ign_run", last_run, 8);
    check("ign_sb_empty", 16'(exp_q.size()), 0);

    // back-to-back words through the DONE cycle
    tick();
    tick();
    load_word(8'h81);
    repeat (5) tick();
    d   = 8'h3C;
    pln = 1'b0;
    wait_done(20, seen);
    check("b2b_done1", seen, 1);
    check("b2b_run1", last_run, 8);
    push_word(8'h3C);
    @(negedge clk);
    #1;
    check("b2b_busy", busy, 1);
    check("b2b_msb", q7, 0);
    pln = 1'b1;
    wait_done(20, seen);
    check("b2b_done2", seen, 1);
    check("b2b_run2", last_run, 8);

    // cascade input fills the register
    tick();
    tick();
    ds = 1'b1;
    load_word(8'h00);
    wait_done(20, seen);
    check("casc_done", seen, 1);
    check("casc_q7_done", q7, 1);
    tick();
    tick();
    check("casc_q7_idle", q7, 1);
    check("casc_busy", busy, 0);
    ds = 1'b0;

    // reset mid-word
    tick();
    load_word(8'hA5);
    tick();
    tick();
    #2;
    mrn = 1'b0;
    #1;
    check("mid_rst_q7", q7, 0);
    check("mid_rst_q7n", q7n, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    exp_q.delete();
    nd = n_done;
    repeat (3) tick();
    mrn = 1'b1;
    repeat (3) tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    check("post_rst_q7", q7, 0);
    check("post_rst_no_done", 16'(n_done - nd), 0);

    check("sb_drained", 16'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
